// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_control slice: FSM states and instruction field positions.
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH,
        READ,
        EXEC,
        WRITE
    } state_t;

    localparam int unsigned TYPE_BIT = 15;
    localparam int unsigned A_BIT    = 12;
    localparam int unsigned COMP_HI  = 11;
    localparam int unsigned COMP_LO  = 6;
    localparam int unsigned DEST_HI  = 5;
    localparam int unsigned DEST_LO  = 3;
    localparam int unsigned JUMP_HI  = 2;
    localparam int unsigned JUMP_LO  = 0;

    // Individual destination bits inside the dest field.
    localparam int unsigned DEST_A = 5;
    localparam int unsigned DEST_D = 4;
    localparam int unsigned DEST_M = 3;

endpackage

// File: rtl/jump_eval.sv
// Jump condition evaluation from the j field and ALU flags (j[2]=lt, j[1]=eq, j[0]=gt).
module jump_eval (
    input  logic [2:0] j,
    input  logic       zr,
    input  logic       ng,
    output logic       take
);

    assign take = (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle control unit for a Hack-style CPU with an external ALU and handshaked memory.
module cpu_control
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] instr_in,
    input  logic             instr_valid,
    output logic             fetch_req,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] addr_m,
    input  logic [WIDTH-1:0] mem_in,
    output logic             read_m,
    output logic             write_m,
    output logic [WIDTH-1:0] mem_out,
    input  logic             mem_ready,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic             zx,
    output logic             nx,
    output logic             zy,
    output logic             ny,
    output logic             f,
    output logic             no,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             zr,
    input  logic             ng
);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] ir;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] mem_out_reg;
    logic [WIDTH-1:0] wr_addr;
    logic [WIDTH-1:0] a_load;
    logic [WIDTH-1:0] pc_inc;
    logic             fetch_q;
    logic             read_q;
    logic             write_q;
    logic             is_c;
    logic             take;

    assign is_c   = ir[TYPE_BIT];
    assign pc_inc = pc + WIDTH'(1);

    always_comb begin
        a_load           = ir;
        a_load[TYPE_BIT] = 1'b0;
    end

    jump_eval u_jump_eval (
        .j    (ir[JUMP_HI:JUMP_LO]),
        .zr   (zr),
        .ng   (ng),
        .take (take)
    );

    // fetch_q is cleared by reset, so the first FETCH after reset spends one
    // cycle without a request and cannot accept an instruction.
    always_comb begin
        next_state = state;
        case (state)
            FETCH: if (fetch_q && instr_valid)
                       next_state = (instr_in[TYPE_BIT] && instr_in[A_BIT]) ? READ : EXEC;
            READ:  if (mem_ready) next_state = EXEC;
            EXEC:  next_state = (is_c && ir[DEST_M]) ? WRITE : FETCH;
            WRITE: if (mem_ready) next_state = FETCH;
            default: next_state = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            fetch_q     <= 1'b0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            a_reg       <= '0;
            d_reg       <= '0;
            pc          <= '0;
            ir          <= '0;
            m_reg       <= '0;
            mem_out_reg <= '0;
            wr_addr     <= '0;
        end else begin
            state   <= next_state;
            fetch_q <= (next_state == FETCH);
            read_q  <= (next_state == READ);
            write_q <= (next_state == WRITE);
            case (state)
                FETCH: if (fetch_q && instr_valid) ir <= instr_in;
                READ:  if (mem_ready) m_reg <= mem_in;
                EXEC: begin
                    if (!is_c) begin
                        a_reg <= a_load;
                        pc    <= pc_inc;
                    end else begin
                        // Jump target and write address both use A as it was before this edge.
                        if (ir[DEST_A]) a_reg <= alu_result;
                        if (ir[DEST_D]) d_reg <= alu_result;
                        pc <= take ? a_reg : pc_inc;
                        if (ir[DEST_M]) begin
                            mem_out_reg <= alu_result;
                            wr_addr     <= a_reg;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign fetch_req = fetch_q;
    assign read_m    = read_q;
    assign write_m   = write_q;
    assign pc_out    = pc;
    assign mem_out   = mem_out_reg;
    assign addr_m    = (state == WRITE) ? wr_addr : a_reg;
    assign alu_x     = d_reg;
    assign alu_y     = ir[A_BIT] ? m_reg : a_reg;

    always_comb begin
        {zx, nx, zy, ny, f, no} = '0;
        if (state == EXEC && is_c)
            {zx, nx, zy, ny, f, no} = ir[COMP_HI:COMP_LO];
    end

endmodule

// File: tb/tb_cpu_control.sv
// Randomized and directed bench for cpu_control with a Hack ALU, a memory model and an instruction-level reference model.
module tb_cpu_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr_in;
    logic        instr_valid;
    logic        fetch_req;
    logic [15:0] pc_out;
    logic [15:0] addr_m;
    logic [15:0] mem_in;
    logic        read_m;
    logic        write_m;
    logic [15:0] mem_out;
    logic        mem_ready;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic        zx, nx, zy, ny, f, no;
    logic [15:0] alu_result;
    logic        zr, ng;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [0:65535];
    logic [15:0] m_a, m_d, m_pc;

    cpu_control #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
        .fetch_req(fetch_req), .pc_out(pc_out), .addr_m(addr_m), .mem_in(mem_in),
        .read_m(read_m), .write_m(write_m), .mem_out(mem_out), .mem_ready(mem_ready),
        .alu_x(alu_x), .alu_y(alu_y), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
        .alu_result(alu_result), .zr(zr), .ng(ng)
    );

    always #5 clk = ~clk;

    // External ALU, built from the control-bit definition.
    logic [15:0] bx, by, bo;
    always_comb begin
        bx = zx ? 16'h0000 : alu_x;
        if (nx) bx = ~bx;
        by = zy ? 16'h0000 : alu_y;
        if (ny) by = ~by;
        bo = f ? (bx + by) : (bx & by);
        if (no) bo = ~bo;
        alu_result = bo;
        zr = (bo == 16'h0000);
        ng = bo[15];
    end

    // Reference semantics of the 18 defined computations.
    function automatic logic [15:0] hack_comp(input logic [5:0] c, input logic [15:0] x, input logic [15:0] y);
        case (c)
            6'b101010: return 16'h0000;
            6'b111111: return 16'h0001;
            6'b111010: return 16'hFFFF;
            6'b001100: return x;
            6'b110000: return y;
            6'b001101: return ~x;
            6'b110001: return ~y;
            6'b001111: return 16'h0000 - x;
            6'b110011: return 16'h0000 - y;
            6'b011111: return x + 16'h0001;
            6'b110111: return y + 16'h0001;
            6'b001110: return x - 16'h0001;
            6'b110010: return y - 16'h0001;
            6'b000010: return x + y;
            6'b010011: return x - y;
            6'b000111: return y - x;
            6'b000000: return x & y;
            6'b010101: return x | y;
            default:   return 16'h0000;
        endcase
    endfunction

    task automatic apply_reset();
        rst = 1'b1; instr_valid = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_a = 16'h0000; m_d = 16'h0000; m_pc = 16'h0000;
    endtask

    // Drives one instruction to completion; returns observations, compares nothing.
    task automatic run_instr(input logic [15:0] instr, input int rd_wait, input int wr_wait,
                             output int cycles, output int rd_cyc, output int wr_cyc,
                             output logic wrote, output logic [15:0] w_addr,
                             output logic [15:0] w_data, output logic bad);
        int n;
        cycles = 0; rd_cyc = 0; wr_cyc = 0; wrote = 1'b0;
        w_addr = 16'h0; w_data = 16'h0; bad = 1'b0; n = 0;
        while (!fetch_req && n < 20) begin @(posedge clk); #1; n++; end
        if (!fetch_req) begin bad = 1'b1; return; end
        instr_in = instr; instr_valid = 1'b1; mem_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        instr_valid = 1'b0;
        cycles = 1;
        while (!fetch_req && cycles < 64) begin
            if (read_m && write_m) bad = 1'b1;
            instr_in = 16'($urandom);
            instr_valid = 1'($urandom_range(0, 1));
            if (read_m) begin
                rd_cyc++;
                mem_ready = (rd_cyc > rd_wait);
                mem_in = mem_ready ? mem[addr_m] : 16'($urandom);
            end else if (write_m) begin
                wr_cyc++;
                mem_ready = (wr_cyc > wr_wait);
                if (mem_ready) begin
                    wrote = 1'b1; w_addr = addr_m; w_data = mem_out;
                    mem[addr_m] = mem_out;
                end
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
                mem_in = 16'($urandom);
            end
            @(posedge clk); #1;
            cycles++;
        end
        instr_valid = 1'b0; mem_ready = 1'b0;
        if (!fetch_req || read_m || write_m) bad = 1'b1;
    endtask

    int          cyc, rc, wc;
    logic        wr, bad;
    logic [15:0] wa, wd;

    task automatic test_reset();
        rst = 1'b1; instr_valid = 1'b1; instr_in = 16'h0005; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (fetch_req !== 1'b0) begin failures++; $display("FAIL reset_fetch_req: got %b expected 0", fetch_req); end
        checks++; if ({read_m, write_m} !== 2'b00) begin failures++; $display("FAIL reset_mem_req: got %b expected 00", {read_m, write_m}); end
        checks++; if (pc_out !== 16'h0000) begin failures++; $display("FAIL reset_pc: got %h expected 0000", pc_out); end
        checks++; if (addr_m !== 16'h0000) begin failures++; $display("FAIL reset_a: got %h expected 0000", addr_m); end
        checks++; if (alu_x !== 16'h0000) begin failures++; $display("FAIL reset_d: got %h expected 0000", alu_x); end
        checks++; if (mem_out !== 16'h0000) begin failures++; $display("FAIL reset_mem_out: got %h expected 0000", mem_out); end
        checks++; if ({zx, nx, zy, ny, f, no} !== 6'b000000) begin failures++; $display("FAIL reset_ctrl: got %b expected 000000", {zx, nx, zy, ny, f, no}); end
        rst = 1'b0;
        @(posedge clk); #1;
        instr_valid = 1'b0; mem_ready = 1'b0;
        checks++; if (fetch_req !== 1'b1) begin failures++; $display("FAIL reset_release_fetch: got %b expected 1", fetch_req); end
        checks++; if (pc_out !== 16'h0000) begin failures++; $display("FAIL reset_valid_ignored: pc got %h expected 0000", pc_out); end
    endtask

    task automatic test_a_instr();
        apply_reset();
        run_instr(16'h0005, 0, 0, cyc, rc, wc, wr, wa, wd, bad);
        checks++; if (bad !== 1'b0) begin failures++; $display("FAIL a_instr_handshake: got %b expected 0", bad); end
        checks++; if (addr_m !== 16'h0005) begin failures++; $display("FAIL a_instr_a: got %h expected 0005", addr_m); end
        checks++; if (pc_out !== 16'h0001) begin failures++; $display("FAIL a_instr_pc: got %h expected 0001", pc_out); end
        checks++; if (cyc !== 2) begin failures++; $display("FAIL a_instr_latency: got %0d expected 2", cyc); end
    endtask

    task automatic test_d_eq_a();
        int wtot;
        apply_reset();
        run_instr(16'h0007, 0, 0, cyc, rc, wc, wr, wa, wd, bad);
        wtot = wc;
        run_instr(16'hEC10, 0, 0, cyc, rc, wc, wr, wa, wd, bad);
        wtot += wc;
        checks++; if (alu_x !== 16'h0007) begin failures++; $display("FAIL d_eq_a_d: got %h expected 0007", alu_x); end
        checks++; if (pc_out !== 16'h0002) begin failures++; $display("FAIL d_eq_a_pc: got %h expected 0002", pc_out); end
        checks++; if (wtot !== 0) begin failures++; $display("FAIL d_eq_a_no_write: got %0d write cycles expected 0", wtot); end
        checks++; if (cyc !== 2) begin failures++; $display("FAIL d_eq_a_latency: got %0d expected 2", cyc); end
    endtask

    task automatic test_read();
        apply_reset();
        run_instr(16'h0010, 0, 0, cyc, rc, wc, wr, wa, wd, bad);
        mem[16'h0010] = 16'h1234;
        run_instr(16'hFC20, 3, 0, cyc, rc, wc, wr, wa, wd, bad);
        checks++; if (rc !== 4) begin failures++; $display("FAIL read_cycles: got %0d expected 4", rc); end
        checks++; if (addr_m !== 16'h1234) begin failures++; $display("FAIL read_a: got %h expected 1234", addr_m); end
        checks++; if (cyc !== 6) begin failures++; $display("FAIL read_latency: got %0d expected 6", cyc); end
        checks++; if (pc_out !== 16'h0002) begin failures++; $display("FAIL read_pc: got %h expected 0002", pc_out); end
    endtask

    task automatic test_write();
        apply_reset();
        run_instr(16'h0005, 0, 0, cyc, rc, wc, wr, wa, wd, bad);
        run_instr(16'hEC10, 0, 0, cyc, rc, wc, wr, wa, wd, bad);
        run_instr(16'h0020, 0, 0, cyc, rc, wc, wr, wa, wd, bad);
        run_instr(16'hE308, 0, 4, cyc, rc, wc, wr, wa, wd, bad);
        checks++; if (wc !== 5) begin failures++; $display("FAIL write_held: got %0d write cycles expected 5", wc); end
        checks++; if ({wr, wa, wd} !== {1'b1, 16'h0020, 16'h0005}) begin failures++; $display("FAIL write_data: got %b %h %h expected 1 0020 0005", wr, wa, wd); end
        checks++; if (cyc !== 7) begin failures++; $display("FAIL write_latency: got %0d expected 7", cyc); end
        run_instr(16'h0030, 0, 0, cyc, rc, wc, wr, wa, wd, bad);
        run_instr(16'hE328, 0, 2, cyc, rc, wc, wr, wa, wd, bad);
        checks++; if (wa !== 16'h0030) begin failures++; $display("FAIL write_addr_pre_a: got %h expected 0030", wa); end
        checks++; if (addr_m !== 16'h0005) begin failures++; $display("FAIL write_a_updated: got %h expected 0005", addr_m); end
    endtask

    task automatic test_jump();
        apply_reset();
        run_instr(16'h0100, 0, 0, cyc, rc, wc, wr, wa, wd, bad);
        run_instr(16'hEE90, 0, 0, cyc, rc, wc, wr, wa, wd, bad);
        run_instr(16'hE304, 0, 0, cyc, rc, wc, wr, wa, wd, bad);
        checks++; if (pc_out !== 16'h0100) begin failures++; $display("FAIL jlt_taken: got %h expected 0100", pc_out); end
        run_instr(16'hEA90, 0, 0, cyc, rc, wc, wr, wa, wd, bad);
        run_instr(16'hE304, 0, 0, cyc, rc, wc, wr, wa, wd, bad);
        checks++; if (pc_out !== 16'h0102) begin failures++; $display("FAIL jlt_zero_not_taken: got %h expected 0102", pc_out); end
        run_instr(16'hEFD0, 0, 0, cyc, rc, wc, wr, wa, wd, bad);
        run_instr(16'hE304, 0, 0, cyc, rc, wc, wr, wa, wd, bad);
        checks++; if (pc_out !== 16'h0104) begin failures++; $display("FAIL jlt_pos_not_taken: got %h expected 0104", pc_out); end
        run_instr(16'hEEA0, 0, 0, cyc, rc, wc, wr, wa, wd, bad);
        run_instr(16'hEA87, 0, 0, cyc, rc, wc, wr, wa, wd, bad);
        checks++; if (pc_out !== 16'hFFFF) begin failures++; $display("FAIL jmp_to_ffff: got %h expected ffff", pc_out); end
        run_instr(16'hEA80, 0, 0, cyc, rc, wc, wr, wa, wd, bad);
        checks++; if (pc_out !== 16'h0000) begin failures++; $display("FAIL pc_wrap: got %h expected 0000", pc_out); end
    endtask

    task automatic test_reset_in_write();
        int n;
        apply_reset();
        run_instr(16'h0005, 0, 0, cyc, rc, wc, wr, wa, wd, bad);
        run_instr(16'hEC10, 0, 0, cyc, rc, wc, wr, wa, wd, bad);
        run_instr(16'h0020, 0, 0, cyc, rc, wc, wr, wa, wd, bad);
        n = 0;
        while (!fetch_req && n < 20) begin @(posedge clk); #1; n++; end
        instr_in = 16'hE308; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0; n = 0;
        while (!write_m && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (write_m !== 1'b1) begin failures++; $display("FAIL rst_write_reached: got %b expected 1", write_m); end
        rst = 1'b1; mem_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if ({write_m, fetch_req} !== 2'b00) begin failures++; $display("FAIL rst_write_req: got %b expected 00", {write_m, fetch_req}); end
        checks++; if (pc_out !== 16'h0000) begin failures++; $display("FAIL rst_write_pc: got %h expected 0000", pc_out); end
        checks++; if ({addr_m, mem_out} !== 32'h0) begin failures++; $display("FAIL rst_write_addr_data: got %h %h expected 0000 0000", addr_m, mem_out); end
        rst = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        checks++; if ({fetch_req, write_m} !== 2'b10) begin failures++; $display("FAIL rst_write_fetch: got %b expected 10", {fetch_req, write_m}); end
    endtask

    task automatic test_random();
        logic [5:0]  comps [18] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
                                    6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
                                    6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};
        logic [15:0] instr, y, res, e_pc, e_wa;
        logic        e_wr, take;
        int          rw, ww, e_cyc;
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            rw = $urandom_range(0, 3);
            ww = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0)
                instr = {1'b0, 15'($urandom)};
            else
                instr = {1'b1, 2'($urandom), 1'($urandom), comps[$urandom_range(0, 17)], 3'($urandom), 3'($urandom)};
            e_wr = 1'b0; e_wa = m_a; res = 16'h0;
            if (!instr[15]) begin
                e_cyc = 2;
                m_a = {1'b0, instr[14:0]};
                e_pc = m_pc + 16'h0001;
            end else begin
                e_cyc = 2 + (instr[12] ? 1 + rw : 0) + (instr[3] ? 1 + ww : 0);
                y = instr[12] ? mem[m_a] : m_a;
                res = hack_comp(instr[11:6], m_d, y);
                take = (instr[2] && $signed(res) < 0) || (instr[1] && res == 16'h0) || (instr[0] && $signed(res) > 0);
                e_pc = take ? m_a : m_pc + 16'h0001;
                e_wr = instr[3];
                if (instr[5]) m_a = res;
                if (instr[4]) m_d = res;
            end
            m_pc = e_pc;
            run_instr(instr, rw, ww, cyc, rc, wc, wr, wa, wd, bad);
            checks++; if (bad !== 1'b0) begin failures++; $display("FAIL rnd_handshake[%0d] instr %h: got %b expected 0", i, instr, bad); end
            checks++; if (cyc !== e_cyc) begin failures++; $display("FAIL rnd_latency[%0d] instr %h: got %0d expected %0d", i, instr, cyc, e_cyc); end
            checks++; if (pc_out !== m_pc) begin failures++; $display("FAIL rnd_pc[%0d] instr %h: got %h expected %h", i, instr, pc_out, m_pc); end
            checks++; if (addr_m !== m_a) begin failures++; $display("FAIL rnd_a[%0d] instr %h: got %h expected %h", i, instr, addr_m, m_a); end
            checks++; if (alu_x !== m_d) begin failures++; $display("FAIL rnd_d[%0d] instr %h: got %h expected %h", i, instr, alu_x, m_d); end
            checks++; if (wr !== e_wr) begin failures++; $display("FAIL rnd_wrote[%0d] instr %h: got %b expected %b", i, instr, wr, e_wr); end
            if (e_wr) begin
                checks++; if ({wa, wd} !== {e_wa, res}) begin failures++; $display("FAIL rnd_write[%0d] instr %h: got %h %h expected %h %h", i, instr, wa, wd, e_wa, res); end
            end
            if (failures > 20) break;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; instr_in = 16'h0; instr_valid = 1'b0; mem_in = 16'h0; mem_ready = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        #1;
        test_reset();
        test_a_instr();
        test_d_eq_a();
        test_read();
        test_write();
        test_jump();
        test_reset_in_write();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
